// File: rtl/alu_dispatch.sv
// Dispatch stage ahead of the basic ALU: selects operands with writeback bypass,
// maps RV32I OP/OP-IMM/LUI/AUIPC fields to ALU op codes, and buffers them in a 2-entry skid FIFO.
module alu_dispatch #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic [REG_ADDR_W-1:0] rs1_idx,
  input  logic [REG_ADDR_W-1:0] rs2_idx,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  illegal
);

  localparam logic [5:0] ALU_OP_PLUS            = 6'd0;
  localparam logic [5:0] ALU_OP_SUB             = 6'd1;
  localparam logic [5:0] ALU_OP_SHIFT_LEFT      = 6'd2;
  localparam logic [5:0] ALU_OP_SET_LESS_THAN   = 6'd3;
  localparam logic [5:0] ALU_OP_SET_LESS_THAN_U = 6'd4;
  localparam logic [5:0] ALU_OP_XOR             = 6'd5;
  localparam logic [5:0] ALU_OP_SHIFT_RIGHT     = 6'd6;
  localparam logic [5:0] ALU_OP_SHIFT_RIGHT_A   = 6'd7;
  localparam logic [5:0] ALU_OP_OR              = 6'd8;
  localparam logic [5:0] ALU_OP_AND             = 6'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic                  illegal;
    logic [5:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [REG_ADDR_W-1:0] rd;
  } entry_t;

  entry_t                mem [2];
  entry_t                dec;
  entry_t                head_entry;
  logic                  head;
  logic                  tail;
  logic [1:0]            count;
  logic                  push;
  logic                  pop;
  logic                  is_op;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;

  // Register x0 is hardwired, so a writeback to it must never be forwarded.
  assign rs1_val = (wb_valid && wb_rd != '0 && wb_rd == rs1_idx) ? wb_data : rs1_data;
  assign rs2_val = (wb_valid && wb_rd != '0 && wb_rd == rs2_idx) ? wb_data : rs2_data;

  always_comb begin
    dec         = '0;
    dec.rd      = rd_in;
    dec.op      = ALU_OP_PLUS;
    is_op       = (opcode == OPC_OP);
    case (opcode)
      OPC_LUI: dec.b = imm;
      OPC_AUIPC: begin
        dec.a = pc;
        dec.b = imm;
      end
      OPC_OP, OPC_OP_IMM: begin
        dec.a = rs1_val;
        dec.b = is_op ? rs2_val : imm;
        case (funct3)
          3'b000: dec.op = (is_op && funct7_5) ? ALU_OP_SUB : ALU_OP_PLUS;
          3'b001: begin
            dec.op      = ALU_OP_SHIFT_LEFT;
            dec.illegal = funct7_5;
          end
          3'b010: begin
            dec.op      = ALU_OP_SET_LESS_THAN;
            dec.illegal = is_op && funct7_5;
          end
          3'b011: begin
            dec.op      = ALU_OP_SET_LESS_THAN_U;
            dec.illegal = is_op && funct7_5;
          end
          3'b100: begin
            dec.op      = ALU_OP_XOR;
            dec.illegal = is_op && funct7_5;
          end
          3'b101: dec.op = funct7_5 ? ALU_OP_SHIFT_RIGHT_A : ALU_OP_SHIFT_RIGHT;
          3'b110: begin
            dec.op      = ALU_OP_OR;
            dec.illegal = is_op && funct7_5;
          end
          default: begin
            dec.op      = ALU_OP_AND;
            dec.illegal = is_op && funct7_5;
          end
        endcase
        // The ALU shifts by the full B value, so only the 5-bit shamt may survive.
        if (funct3[1:0] == 2'b01) begin
          dec.b = {{(DATA_WIDTH-5){1'b0}}, dec.b[4:0]};
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.op = ALU_OP_PLUS;
      dec.a  = '0;
      dec.b  = '0;
    end
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[tail] <= dec;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_entry = mem[head];
  assign alu_op     = head_entry.op;
  assign alu_a      = head_entry.a;
  assign alu_b      = head_entry.b;
  assign rd_out     = head_entry.rd;
  assign illegal    = head_entry.illegal;

endmodule
